// File: rtl/ntt_stage_ctrl_if.sv
// Handshake and memory-side bundle for the NTT stage sequencer.
// master = transform controller / testbench, slave = sequencer.
interface ntt_stage_ctrl_if #(
  parameter int unsigned LOG_N = 8
);
  logic             start_i;
  logic             inv_i;
  logic             red_i;
  logic             stall_i;
  logic             rd_valid_o;
  logic [LOG_N-1:0] rd_a_addr_o;
  logic [LOG_N-1:0] rd_b_addr_o;
  logic [LOG_N-1:0] twiddle_addr_o;
  logic             sel_butterfly_o;
  logic             sel_red_o;
  logic             wr_en_o;
  logic [LOG_N-1:0] wr_a_addr_o;
  logic [LOG_N-1:0] wr_b_addr_o;
  logic             busy_o;
  logic             done_o;

  modport master (
    output start_i, inv_i, red_i, stall_i,
    input  rd_valid_o, rd_a_addr_o, rd_b_addr_o, twiddle_addr_o,
           sel_butterfly_o, sel_red_o, wr_en_o, wr_a_addr_o, wr_b_addr_o,
           busy_o, done_o
  );

  modport slave (
    input  start_i, inv_i, red_i, stall_i,
    output rd_valid_o, rd_a_addr_o, rd_b_addr_o, twiddle_addr_o,
           sel_butterfly_o, sel_red_o, wr_en_o, wr_a_addr_o, wr_b_addr_o,
           busy_o, done_o
  );
endinterface

// File: rtl/ntt_stage_ctrl.sv
// In-place NTT / inverse-NTT sequencer: issues one butterfly operand pair per
// cycle and replays the same addresses LAT cycles later for write-back.
module ntt_stage_ctrl #(
  parameter int unsigned LOG_N = 8,
  parameter int unsigned LAT   = 2
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  ntt_stage_ctrl_if.slave   bus
);
  localparam int unsigned LW = (LOG_N > 1) ? $clog2(LOG_N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [LW-1:0]    r_l;
  logic [LOG_N-2:0] r_bf;
  logic [3:0]       r_drain;
  logic             r_inv, r_red;
  logic             r_dv [LAT];
  logic [LOG_N-1:0] r_da [LAT];
  logic [LOG_N-1:0] r_db [LAT];

  logic             w_rd_valid;
  logic [LW:0]      w_s;
  logic [LOG_N-1:0] w_len, w_g, w_j, w_a, w_b, w_gcnt, w_tw;
  logic [LOG_N-1:0] w_rd_a, w_rd_b;

  // s widened by one bit so the group shift (s+1) can reach LOG_N
  always_comb begin
    w_s    = r_inv ? {1'b0, r_l} : (LW+1)'(LOG_N-1) - {1'b0, r_l};
    w_len  = LOG_N'(1) << w_s;
    w_g    = {1'b0, r_bf} >> w_s;
    w_j    = {1'b0, r_bf} & (w_len - LOG_N'(1));
    w_a    = (w_g << (w_s + (LW+1)'(1))) | w_j;
    w_b    = w_a | w_len;
    w_gcnt = LOG_N'(1) << ((LW+1)'(LOG_N-1) - w_s);
    w_tw   = r_inv ? (w_gcnt << 1) - LOG_N'(1) - w_g : w_gcnt + w_g;
  end

  assign w_rd_valid = (r_state == S_ISSUE) && !bus.stall_i;
  assign w_rd_a     = (r_state == S_ISSUE) ? w_a : '0;
  assign w_rd_b     = (r_state == S_ISSUE) ? w_b : '0;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start_i) w_next = S_ISSUE;
      S_ISSUE: if (w_rd_valid && (r_bf == '1)) w_next = S_DRAIN;
      S_DRAIN: if (r_drain == 4'(LAT-1))
                 w_next = (r_l == LW'(LOG_N-1)) ? S_DONE : S_ISSUE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state <= S_IDLE;
      r_l     <= '0;
      r_bf    <= '0;
      r_drain <= '0;
      r_inv   <= 1'b0;
      r_red   <= 1'b0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: if (bus.start_i) begin
          r_inv   <= bus.inv_i;
          r_red   <= bus.red_i;
          r_l     <= '0;
          r_bf    <= '0;
          r_drain <= '0;
        end
        S_ISSUE: if (w_rd_valid) r_bf <= r_bf + 1'b1;
        S_DRAIN: if (r_drain == 4'(LAT-1)) begin
          r_drain <= '0;
          if (r_l != LW'(LOG_N-1)) r_l <= r_l + 1'b1;
        end else begin
          r_drain <= r_drain + 4'd1;
        end
        default: ;
      endcase
    end
  end

  // Write-back delay line shifts unconditionally so bubbles stay aligned
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      for (int unsigned i = 0; i < LAT; i++) begin
        r_dv[i] <= 1'b0;
        r_da[i] <= '0;
        r_db[i] <= '0;
      end
    end else begin
      r_dv[0] <= w_rd_valid;
      r_da[0] <= w_rd_a;
      r_db[0] <= w_rd_b;
      for (int unsigned i = 1; i < LAT; i++) begin
        r_dv[i] <= r_dv[i-1];
        r_da[i] <= r_da[i-1];
        r_db[i] <= r_db[i-1];
      end
    end
  end

  assign bus.rd_valid_o      = w_rd_valid;
  assign bus.rd_a_addr_o     = w_rd_a;
  assign bus.rd_b_addr_o     = w_rd_b;
  assign bus.twiddle_addr_o  = (r_state == S_ISSUE) ? w_tw : '0;
  assign bus.sel_butterfly_o = r_inv;
  assign bus.sel_red_o       = r_red;
  assign bus.wr_en_o         = r_dv[LAT-1];
  assign bus.wr_a_addr_o     = r_da[LAT-1];
  assign bus.wr_b_addr_o     = r_db[LAT-1];
  assign bus.busy_o          = (r_state == S_ISSUE) || (r_state == S_DRAIN);
  assign bus.done_o          = (r_state == S_DONE);
endmodule

// File: tb/tb_ntt_stage_ctrl.sv
// Bench for ntt_stage_ctrl: per-cycle comparison against a loop-nest model of
// the NTT butterfly schedule, with random/directed stalls and mid-run reset.
module tb_ntt_stage_ctrl;
  localparam int unsigned LOG_N = 8;
  localparam int unsigned LAT   = 2;
  localparam int N     = 1 << LOG_N;
  localparam int HALF  = N / 2;
  localparam int TOTAL = LOG_N * HALF;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ntt_stage_ctrl_if #(.LOG_N(LOG_N)) bus ();
  ntt_stage_ctrl #(.LOG_N(LOG_N), .LAT(LAT)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;
  int ea [TOTAL], eb [TOTAL], ek [TOTAL];
  int oa [TOTAL], ob [TOTAL], ok [TOTAL];
  bit hv [4096];
  int ha [4096], hb [4096];
  int wr_pulses, first_wr, last_wr, n_stalls, d;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Schedule from the textbook loop nest: layer, group, offset within group
  task automatic build_model(input bit inv);
    int idx = 0;
    for (int l = 0; l < LOG_N; l++) begin
      int s   = inv ? l : LOG_N - 1 - l;
      int len = 1 << s;
      int G   = HALF / len;
      for (int g = 0; g < G; g++)
        for (int j = 0; j < len; j++) begin
          ea[idx] = g * 2 * len + j;
          eb[idx] = ea[idx] + len;
          ek[idx] = inv ? 2 * G - 1 - g : G + g;
          idx++;
        end
    end
  endtask

  task automatic check_zero();
    chk("z_rd_valid", bus.rd_valid_o, 0);
    chk("z_rd_a", bus.rd_a_addr_o, 0);
    chk("z_rd_b", bus.rd_b_addr_o, 0);
    chk("z_twiddle", bus.twiddle_addr_o, 0);
    chk("z_sel_bf", bus.sel_butterfly_o, 0);
    chk("z_sel_red", bus.sel_red_o, 0);
    chk("z_wr_en", bus.wr_en_o, 0);
    chk("z_wr_a", bus.wr_a_addr_o, 0);
    chk("z_wr_b", bus.wr_b_addr_o, 0);
    chk("z_busy", bus.busy_o, 0);
    chk("z_done", bus.done_o, 0);
  endtask

  task automatic run(input bit inv, input bit red, input int st_idx, input int st_n,
                     input bit rnd, input bit poke, input int rst_idx, output int done_cyc);
    int idx = 0, gap = 0, stall_left = st_n;
    bit issuing, ev, fin, stall, expv;
    build_model(inv);
    wr_pulses = 0; first_wr = -1; last_wr = -1; n_stalls = 0; done_cyc = -1;
    @(negedge clk);
    bus.start_i = 1'b1; bus.inv_i = inv; bus.red_i = red; bus.stall_i = 1'b0;
    @(posedge clk);
    for (int c = 1; c <= 3000; c++) begin
      @(negedge clk);
      bus.start_i = 1'b0; bus.inv_i = inv; bus.red_i = red;
      if (poke && c > 1 && $urandom_range(0, 9) == 0) begin
        bus.start_i = 1'b1;
        bus.inv_i   = 1'($urandom_range(0, 1));
        bus.red_i   = 1'($urandom_range(0, 1));
      end
      issuing = (gap == 0) && (idx < TOTAL);
      fin     = (gap == 0) && (idx == TOTAL);
      if (rst_idx >= 0 && issuing && idx == rst_idx) begin
        bus.stall_i = 1'b0; bus.start_i = 1'b0;
        rst_n = 1'b0;
        #1 check_zero();
        repeat (4) begin @(negedge clk); #1 check_zero(); end
        @(negedge clk); rst_n = 1'b1;
        repeat (LAT + 3) begin @(negedge clk); #1 check_zero(); end
        return;
      end
      if (issuing && idx == st_idx && stall_left > 0) begin
        stall = 1'b1; stall_left--;
      end else begin
        stall = rnd && ($urandom_range(0, 3) == 0);
      end
      bus.stall_i = stall;
      ev = issuing && !stall;
      #1;
      chk("rd_valid", bus.rd_valid_o, ev);
      if (issuing) begin
        chk("rd_a_addr", bus.rd_a_addr_o, ea[idx]);
        chk("rd_b_addr", bus.rd_b_addr_o, eb[idx]);
        chk("twiddle_addr", bus.twiddle_addr_o, ek[idx]);
      end
      if (ev) begin
        oa[idx] = int'(bus.rd_a_addr_o);
        ob[idx] = int'(bus.rd_b_addr_o);
        ok[idx] = int'(bus.twiddle_addr_o);
      end
      chk("busy", bus.busy_o, !fin);
      chk("done", bus.done_o, fin);
      chk("sel_butterfly", bus.sel_butterfly_o, inv);
      chk("sel_red", bus.sel_red_o, red);
      expv = (c > int'(LAT)) ? hv[c-LAT] : 1'b0;
      chk("wr_en", bus.wr_en_o, expv);
      if (expv) begin
        chk("wr_a_addr", bus.wr_a_addr_o, ha[c-LAT]);
        chk("wr_b_addr", bus.wr_b_addr_o, hb[c-LAT]);
      end
      if (bus.wr_en_o === 1'b1) begin
        wr_pulses++;
        if (first_wr < 0) first_wr = c;
        last_wr = c;
      end
      hv[c] = ev;
      if (ev) begin ha[c] = ea[idx]; hb[c] = eb[idx]; end
      if (issuing && stall) n_stalls++;
      if (ev) begin
        idx++;
        if (idx % HALF == 0) gap = LAT;
      end else if (gap > 0) begin
        gap--;
      end
      if (fin) begin done_cyc = c; break; end
    end
    bus.start_i = 1'b0; bus.stall_i = 1'b0;
    if (done_cyc < 0) begin
      checks++; errors++;
      $error("FAIL done_timeout: observed no done_o, expected one within 3000 cycles");
    end
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start_i = 1'b0; bus.inv_i = 1'b0; bus.red_i = 1'b0; bus.stall_i = 1'b0;
    repeat (3) @(negedge clk);
    #1 check_zero();
    @(negedge clk); rst_n = 1'b1;
    #1 check_zero();
    repeat (2) begin @(negedge clk); #1 check_zero(); end

    // Forward, no stall
    run(1'b0, 1'b0, -1, 0, 1'b0, 1'b0, -1, d);
    chk("fwd_done_cycle", d, LOG_N * (HALF + LAT) + 1);
    chk("fwd_done_1041", d, 1041);
    chk("fwd_wr_pulses", wr_pulses, 1024);
    chk("fwd_bubbles", last_wr - first_wr + 1 - wr_pulses, 7 * LAT);
    chk("fwd_l0b0_a", oa[0], 0);   chk("fwd_l0b0_b", ob[0], 128); chk("fwd_l0b0_k", ok[0], 1);
    chk("fwd_l0b1_a", oa[1], 1);   chk("fwd_l0b1_b", ob[1], 129); chk("fwd_l0b1_k", ok[1], 1);
    chk("fwd_l1b64_a", oa[192], 128); chk("fwd_l1b64_b", ob[192], 192); chk("fwd_l1b64_k", ok[192], 3);
    chk("fwd_l7b127_a", oa[1023], 254); chk("fwd_l7b127_b", ob[1023], 255); chk("fwd_l7b127_k", ok[1023], 255);

    // Inverse, no stall
    run(1'b1, 1'b0, -1, 0, 1'b0, 1'b0, -1, d);
    chk("inv_done_cycle", d, 1041);
    chk("inv_wr_pulses", wr_pulses, 1024);
    chk("inv_l0b0_a", oa[0], 0);   chk("inv_l0b0_b", ob[0], 1);   chk("inv_l0b0_k", ok[0], 255);
    chk("inv_l0b1_a", oa[1], 2);   chk("inv_l0b1_b", ob[1], 3);   chk("inv_l0b1_k", ok[1], 254);
    chk("inv_l0b127_a", oa[127], 254); chk("inv_l0b127_b", ob[127], 255); chk("inv_l0b127_k", ok[127], 128);
    chk("inv_l7b5_a", oa[901], 5); chk("inv_l7b5_b", ob[901], 133); chk("inv_l7b5_k", ok[901], 1);

    // Directed 3-cycle stall at layer 2, bf10
    run(1'b0, 1'b0, 2 * HALF + 10, 3, 1'b0, 1'b0, -1, d);
    chk("stall_done_cycle", d, 1044);
    chk("stall_wr_pulses", wr_pulses, 1024);
    chk("stall_bubbles", last_wr - first_wr + 1 - wr_pulses, 7 * LAT + 3);

    // Random stalls, start pokes while busy, red=1
    run(1'b1, 1'b1, -1, 0, 1'b1, 1'b1, -1, d);
    chk("rnd_done_cycle", d, LOG_N * (HALF + LAT) + 1 + n_stalls);
    chk("rnd_wr_pulses", wr_pulses, 1024);
    repeat (3) @(negedge clk);
    #1;
    chk("idle_sel_red_hold", bus.sel_red_o, 1);
    chk("idle_sel_bf_hold", bus.sel_butterfly_o, 1);
    chk("idle_busy", bus.busy_o, 0);

    // Reset mid-transform at layer 3, bf40, then a clean restart
    run(1'b0, 1'b1, -1, 0, 1'b0, 1'b0, 3 * HALF + 40, d);
    run(1'b0, 1'b0, -1, 0, 1'b0, 1'b0, -1, d);
    chk("post_rst_done_cycle", d, 1041);
    chk("post_rst_wr_pulses", wr_pulses, 1024);
    chk("post_rst_first_a", oa[0], 0);
    chk("post_rst_first_b", ob[0], 128);
    chk("post_rst_first_k", ok[0], 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
